// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the tick_gen multi-channel tick divider.
// The optional square-wave outputs are enabled by defining TICK_GEN_SQ_EN.
package tick_gen_pkg;

  // Reset divisor: 500 ms tick at a 100 MHz clock.
  localparam int unsigned DEF_DIV   = 50000000;
  localparam int unsigned DEF_CNT_W = 30;

  // Widest counter the clamp helper handles; CNT_W must not exceed this.
  localparam int unsigned MAX_CNT_W = 64;

  // A divisor of 0 would never terminate the count, so it behaves as 1.
  function automatic logic [MAX_CNT_W-1:0] clamp_div(input logic [MAX_CNT_W-1:0] d);
    logic [MAX_CNT_W-1:0] r;
    r = d;
    if (d == '0) begin
      r = {{(MAX_CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// One divider channel: divisor register, free-running counter, registered
// one-cycle tick and, when TICK_GEN_SQ_EN is defined, a registered square wave.
// clr_i (load or sync) always beats a terminal count: no tick on a clear edge.
module tick_gen_ch #(
  parameter int unsigned CNT_W   = tick_gen_pkg::DEF_CNT_W,
  parameter int unsigned DEF_DIV = tick_gen_pkg::DEF_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
`ifdef TICK_GEN_SQ_EN
  output logic             sq_o,
`endif
  output logic             tick_o
);
  import tick_gen_pkg::*;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(clamp_div(MAX_CNT_W'(DEF_DIV)));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             term;
`ifdef TICK_GEN_SQ_EN
  logic             sq_q, sq_d;
`endif

  // Last count of the period; div_q is never 0 so this cannot wrap.
  assign term = (cnt_q == (div_q - ONE));

  // Next-state: divisor write, clear, count/terminal, or hold.
  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    tick_d = 1'b0;
`ifdef TICK_GEN_SQ_EN
    sq_d   = sq_q;
`endif
    if (wr_i) begin
      div_d = CNT_W'(clamp_div(MAX_CNT_W'(wr_div_i)));
    end
    if (clr_i) begin
      cnt_d = '0;
`ifdef TICK_GEN_SQ_EN
      sq_d  = 1'b0;
`endif
    end else if (en_i) begin
      if (term) begin
        cnt_d  = '0;
        tick_d = 1'b1;
`ifdef TICK_GEN_SQ_EN
        sq_d   = ~sq_q;
`endif
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // State registers with asynchronous reset to the default divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= RST_DIV;
      tick_q <= 1'b0;
`ifdef TICK_GEN_SQ_EN
      sq_q   <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
`ifdef TICK_GEN_SQ_EN
      sq_q   <= sq_d;
`endif
    end
  end

  assign tick_o = tick_q;
`ifdef TICK_GEN_SQ_EN
  assign sq_o   = sq_q;
`endif

endmodule

// File: rtl/tick_gen.sv
// tick_gen: N_CH independent programmable tick dividers on one clock.
// Define TICK_GEN_SQ_EN to add the per-channel square-wave output sq.
// Strobes: load and sync are single-cycle, sampled on the rising edge they
// are high; there is no back-pressure, every strobe takes effect that edge.
module tick_gen #(
  parameter int          N_CH    = 4,
  parameter int unsigned CNT_W   = tick_gen_pkg::DEF_CNT_W,
  parameter int unsigned DEF_DIV = tick_gen_pkg::DEF_DIV,
  localparam int         LC_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  en,
  input  logic             load,
  input  logic [LC_W-1:0]  load_ch,
  input  logic [CNT_W-1:0] load_div,
  input  logic             sync,
`ifdef TICK_GEN_SQ_EN
  output logic [N_CH-1:0]  sq,
`endif
  output logic [N_CH-1:0]  tick
);
  import tick_gen_pkg::*;

  logic [N_CH-1:0] load_hit;
  logic            load_ok;

  // An index beyond the last channel is dropped rather than aliased.
  assign load_ok = load && (int'(load_ch) < N_CH);

  // One-hot decode of the load target channel.
  always_comb begin
    load_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      load_hit[i] = load_ok && (int'(load_ch) == i);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tick_gen_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (en[i]),
      .clr_i    (sync | load_hit[i]),
      .wr_i     (load_hit[i]),
      .wr_div_i (load_div),
`ifdef TICK_GEN_SQ_EN
      .sq_o     (sq[i]),
`endif
      .tick_o   (tick[i])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen (N_CH=4 and N_CH=3, CNT_W=8, DEF_DIV=5).
// Square-wave checks are active when TICK_GEN_SQ_EN is defined.
module tb_tick_gen;
  localparam int VW = 14;

  logic       clk;
  logic       rst_n;
  logic [3:0] en;
  logic       load;
  logic [1:0] load_ch;
  logic [7:0] load_div;
  logic       sync;
  logic [3:0] tick;
  logic       load3;
  logic [1:0] load_ch3;
  logic [7:0] load_div3;
  logic [2:0] tick3;
  logic [3:0] sq_act;
  logic [2:0] sq3_act;

`ifdef TICK_GEN_SQ_EN
  logic [3:0] sq;
  logic [2:0] sq3;
  assign sq_act  = sq;
  assign sq3_act = sq3;
`else
  assign sq_act  = '0;
  assign sq3_act = '0;
`endif

  tick_gen #(.N_CH(4), .CNT_W(8), .DEF_DIV(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .load_ch  (load_ch),
    .load_div (load_div),
    .sync     (sync),
`ifdef TICK_GEN_SQ_EN
    .sq       (sq),
`endif
    .tick     (tick)
  );

  // Three-channel instance so a 2-bit load_ch can address a missing channel.
  tick_gen #(.N_CH(3), .CNT_W(8), .DEF_DIV(5)) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en[2:0]),
    .load     (load3),
    .load_ch  (load_ch3),
    .load_div (load_div3),
    .sync     (sync),
`ifdef TICK_GEN_SQ_EN
    .sq       (sq3),
`endif
    .tick     (tick3)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  logic [VW-1:0] exp_q[$];
  string         tag_q[$];
  int            n_vec;
  int            n_err;
  event          chk_ev;

  // Monitor: one expected vector is consumed per rising edge (or per
  // explicit mid-cycle check) and compared against the live outputs.
  initial begin
    logic [VW-1:0] exp_v;
    logic [VW-1:0] act_v;
    string         tag;
    n_vec = 0;
    n_err = 0;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        tag   = tag_q.pop_front();
        act_v = {tick3, sq3_act, tick, sq_act};
        n_vec++;
        if (act_v !== exp_v) begin
          n_err++;
          $display("FAIL %s @%0t: got tick3=%b sq3=%b tick=%b sq=%b, expected tick3=%b sq3=%b tick=%b sq=%b",
                   tag, $time, act_v[13:11], act_v[10:8], act_v[7:4], act_v[3:0],
                   exp_v[13:11], exp_v[10:8], exp_v[7:4], exp_v[3:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input string tag, input logic [2:0] t3, input logic [2:0] s3,
                      input logic [3:0] t, input logic [3:0] s);
    logic [2:0] s3m;
    logic [3:0] sm;
    s3m = s3;
    sm  = s;
`ifndef TICK_GEN_SQ_EN
    s3m = '0;
    sm  = '0;
`endif
    exp_q.push_back({t3, s3m, t, sm});
    tag_q.push_back(tag);
  endtask

  // Expectation for the outputs just after the coming rising edge.
  task automatic cyc(input string tag, input logic [2:0] t3, input logic [2:0] s3,
                     input logic [3:0] t, input logic [3:0] s);
    push(tag, t3, s3, t, s);
    @(negedge clk);
  endtask

  // Reset with enables high: outputs must be zero at once and stay zero.
  task automatic do_reset();
    en    = 4'hF;
    load  = 1'b0;
    load3 = 1'b0;
    sync  = 1'b0;
    rst_n = 1'b0;
    push("reset_state", 3'b0, 3'b0, 4'b0, 4'b0);
    ->chk_ev;
    cyc("reset_hold", 3'b0, 3'b0, 4'b0, 4'b0);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] t;
    logic [3:0] s;
    logic [2:0] t3;
    logic [2:0] s3;
    int         e;
    int         last;

    rst_n     = 1'b0;
    en        = '0;
    load      = 1'b0;
    load_ch   = '0;
    load_div  = '0;
    sync      = 1'b0;
    load3     = 1'b0;
    load_ch3  = '0;
    load_div3 = '0;
    @(negedge clk);

    // Free run from reset: all channels tick at 5, 10, 15.
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      t = (k % 5 == 0) ? 4'hF : 4'h0;
      s = ((k / 5) % 2 == 1) ? 4'hF : 4'h0;
      cyc("free_run", t[2:0], s[2:0], t, s);
    end

    // Load ch2 with divisor 3 on edge 3: ticks at 6, 9, 12, 15.
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        load     = 1'b1;
        load_ch  = 2'd2;
        load_div = 8'd3;
      end
      t  = (k % 5 == 0) ? 4'hF : 4'h0;
      s  = ((k / 5) % 2 == 1) ? 4'hF : 4'h0;
      t3 = t[2:0];
      s3 = s[2:0];
      t[2] = (k > 3) && ((k - 3) % 3 == 0);
      s[2] = (k > 3) && (((k - 3) / 3) % 2 == 1);
      cyc("load_div3", t3, s3, t, s);
      load = 1'b0;
    end

    // Divisor 0 on ch0 (tick every cycle), then out-of-range load on dut3.
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) begin
        load      = 1'b1;
        load_ch   = 2'd0;
        load_div  = 8'd0;
        load3     = 1'b1;
        load_ch3  = 2'd0;
        load_div3 = 8'd0;
      end
      if (k == 3) begin
        load3     = 1'b1;
        load_ch3  = 2'd3;
        load_div3 = 8'd2;
      end
      t    = (k % 5 == 0) ? 4'hF : 4'h0;
      s    = ((k / 5) % 2 == 1) ? 4'hF : 4'h0;
      t[0] = (k >= 2);
      s[0] = (k >= 2) && ((k - 1) % 2 == 1);
      cyc("div0_and_bad_ch", t[2:0], s[2:0], t, s);
      load  = 1'b0;
      load3 = 1'b0;
    end

    // en[1] low for edges 3..9 with cnt=2: ch1 ticks at 12 and 17.
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      en[1] = !(k >= 3 && k <= 9);
      e     = (k <= 2) ? k : ((k <= 9) ? 2 : k - 7);
      t     = (k % 5 == 0) ? 4'hF : 4'h0;
      s     = ((k / 5) % 2 == 1) ? 4'hF : 4'h0;
      t[1]  = (k < 3 || k > 9) && (e % 5 == 0);
      s[1]  = ((e / 5) % 2 == 1);
      cyc("en_gap", t[2:0], s[2:0], t, s);
    end
    en = 4'hF;

    // sync mid-period (edge 7) and on a terminal count (edge 17).
    do_reset();
    last = 0;
    for (int k = 1; k <= 23; k++) begin
      if (k == 7 || k == 17) begin
        sync = 1'b1;
        t    = 4'h0;
        s    = 4'h0;
        last = k;
      end else begin
        e = k - last;
        t = (e % 5 == 0) ? 4'hF : 4'h0;
        s = ((e / 5) % 2 == 1) ? 4'hF : 4'h0;
      end
      cyc("sync", t[2:0], s[2:0], t, s);
      sync = 1'b0;
    end

    // Asynchronous reset between edges at cnt=3 with sq high.
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      t = (k == 5) ? 4'hF : 4'h0;
      s = (k >= 5) ? 4'hF : 4'h0;
      cyc("pre_async", t[2:0], s[2:0], t, s);
    end
    #2;
    rst_n = 1'b0;
    push("async_reset", 3'b0, 3'b0, 4'b0, 4'b0);
    ->chk_ev;
    cyc("async_hold", 3'b0, 3'b0, 4'b0, 4'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      t = (k == 5) ? 4'hF : 4'h0;
      s = (k >= 5) ? 4'hF : 4'h0;
      cyc("post_async", t[2:0], s[2:0], t, s);
    end

    // ---------------- final report ----------------
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected vectors left uncompared, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
